cic_comp_fir: RTL
=================

# cic_comp_fir

Seven-tap symmetric droop-compensation FIR that sits directly downstream of the CIC decimator. It consumes decimated CIC output samples and flattens the CIC sinc passband droop. It emits one rounded, saturated sample per accepted input. A single time-multiplexed multiplier runs in the fast system clock domain, with a valid/ready handshake at each side.

## Interface
- DW, 16: sample width of data_in and data_out, signed two's complement.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  data_in carries a new decimated sample this cycle.
- in_ready  output  1  block can accept a sample this cycle.
- data_in  input  DW  signed CIC output sample.
- bypass  input  1  1 = pass the sample through unfiltered, with identical latency; sampled at acceptance.
- clr_ovr  input  1  synchronous clear of the overrun flag.
- out_valid  output  1  one-cycle pulse; data_out holds a new sample.
- data_out  output  DW  signed filtered sample; held until the next out_valid.
- overrun  output  1  sticky; set when in_valid=1 while in_ready=0.

## Operation
- Coefficients are fixed and 9-bit signed: h0..h6 = -2, 5, -14, 86, -14, 5, -2. They sum to 64, so DC gain is 1 after the shift by 6.
- Delay line x0..x6 holds DW-bit samples; x0 is the newest.
- On accept (in_valid & in_ready): x shifts by one, x0 <= data_in, the bypass flag is latched, acc <= 0, and the state goes to MAC.
- States:
  - IDLE (in_ready=1).
  - MAC: 4 cycles, step counter k = 0..3.
  - OUT: 1 cycle.
- MAC step k:
  - k = 0..2: acc += h_k * (x_k + x_(6-k)). The pre-add is DW+1 bits.
  - k = 3: acc += 86 * x3.
  - Accumulator is DW+12 bits, sign-extended; it never overflows.
  - After k = 3, go to OUT.
- OUT:
  - y = (acc + 32) >>> 6, an arithmetic shift with round-half-up.
  - Saturate y to [-2^(DW-1), 2^(DW-1)-1].
  - If bypass was latched, y = x0 instead.
  - data_out <= y, out_valid <= 1 for exactly one cycle, then return to IDLE.
- in_valid while not in IDLE: the sample is dropped, overrun <= 1, and the filter state is untouched.
- clr_ovr=1 clears overrun. If a drop and clr_ovr occur in the same cycle, set wins.
- in_ready is combinational from state: 1 only in IDLE. in_valid with in_ready=0 is never back-pressured; the upstream CIC cannot stall.

## Timing
- Reset values:
  - in_ready = 1, out_valid = 0, data_out = 0, overrun = 0.
  - x0..x6 = 0, acc = 0, state = IDLE.
- Accept at edge E.
  - MAC steps occur at edges E+1..E+4.
  - data_out and out_valid update at edge E+5, so out_valid is high between E+5 and E+6.
  - Latency from accept to out_valid is 5 clocks.
- in_ready rises at edge E+5. The earliest next accept is edge E+6, so throughput is 1 sample per 6 clocks.
- The CIC decimation ratio times the CIC clock ratio must give at least 6 clk per sample; otherwise samples are dropped and overrun is set.
- Reset asserted mid-MAC or in OUT:
  - Immediate return to reset values; the partial result is discarded and no out_valid is produced.
  - The first accept is possible at the first rising edge after reset deasserts.
- bypass changes outside acceptance have no effect on an in-flight sample.

## Test plan
- Impulse: DW=16, data_in 6400 followed by zeros, each accepted 6 clocks apart -> data_out sequence -200, 500, -1400, 8600, -1400, 500, -200, then 0. Each out_valid comes 5 clocks after its accept.
- DC: 20 samples of 1000 -> after the 7th output, every data_out = 1000. Rounding check: a single sample of 1 gives outputs 0, 0, 0, 1, 0, 0, 0.
- Saturation: alternating +32767 / -32768 -> steady-state outputs alternate -32768 / +32767 (gain -2, clipped). No wrap-around values appear.
- Overrun: in_valid held high continuously -> accepts every 6th clock only, overrun rises on the first dropped cycle and stays high. clr_ovr clears it, but it re-sets in the same cycle if a drop coincides.
- Bypass: bypass=1 with input 12345 -> data_out 12345 after 5 clocks. Toggling bypass mid-MAC does not change that output.
- Reset mid-operation: assert reset at edge E+2 after an accept of 5000 -> out_valid never pulses and data_out = 0. After release, an impulse of 6400 reproduces the impulse sequence, confirming the delay line was cleared.

Source files
------------

// File: rtl/cic_comp_fir.sv
// Seven-tap symmetric droop-compensation FIR for the CIC decimator output.
// One multiplier is reused over four MAC cycles, so each sample takes 6 clocks.
module cic_comp_fir #(
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] data_in,
  input  logic                 bypass,
  input  logic                 clr_ovr,
  output logic                 out_valid,
  output logic signed [DW-1:0] data_out,
  output logic                 overrun
);

  localparam int AW = DW + 12;
  localparam logic signed [AW-1:0] RND = AW'(32);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t               state;
  logic [1:0]           k;
  logic signed [DW-1:0] x [0:6];
  logic signed [AW-1:0] acc;
  logic                 byp;

  logic signed [DW:0]   pre;
  logic signed [8:0]    coef;
  logic signed [AW-1:0] prod;
  logic signed [AW-1:0] y_full;
  logic signed [DW-1:0] y_sat;

  assign in_ready = (state == IDLE);

  // Symmetric taps share one multiply: pre-add the mirrored pair, then scale.
  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    pre  = '0;
    coef = '0;
    case (k)
      2'd0: begin
        pre  = {x[0][DW-1], x[0]} + {x[6][DW-1], x[6]};
        coef = -9'sd2;
      end
      2'd1: begin
        pre  = {x[1][DW-1], x[1]} + {x[5][DW-1], x[5]};
        coef = 9'sd5;
      end
      2'd2: begin
        pre  = {x[2][DW-1], x[2]} + {x[4][DW-1], x[4]};
        coef = -9'sd14;
      end
      default: begin
        pre  = {x[3][DW-1], x[3]};
        coef = 9'sd86;
      end
    endcase
    prod = $signed({{(AW-9){coef[8]}}, coef}) * $signed({{(AW-DW-1){pre[DW]}}, pre});
  end

  // Round half-up, drop the 6 fractional bits, then clip to the DW-bit range.
  always_comb begin
    y_full = (acc + RND) >>> 6;
    if (y_full[AW-1:DW-1] != {(AW-DW+1){y_full[AW-1]}}) begin
      y_sat = y_full[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      y_sat = y_full[DW-1:0];
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      acc       <= '0;
      byp       <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
      overrun   <= 1'b0;
      // NOTE: the delay line is reset so an aborted sample cannot leak into later outputs.
      for (int i = 0; i < 7; i++) x[i] <= '0;
    end else begin
      out_valid <= 1'b0;

      // A drop in the same cycle as a clear keeps the flag set.
      if (in_valid && !in_ready) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 6; i > 0; i--) x[i] <= x[i-1];
            x[0]  <= data_in;
            byp   <= bypass;
            acc   <= '0;
            k     <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc + prod;
          k   <= k + 2'd1;
          if (k == 2'd3) state <= OUT;
        end
        OUT: begin
          data_out  <= byp ? x[0] : y_sat;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
